vga_draw_engine: RTL
====================

VGA_DRAW_ENGINE -- requirements
Module: vga_draw_engine

Interface
REQ-001 Parameter BASE_ADDR, default 8'hB0: bus address of register 0; the block decodes BASE_ADDR..BASE_ADDR+5.
REQ-002 Parameter H_BITS, default 8: horizontal coordinate width.
REQ-003 Parameter V_BITS, default 7: vertical coordinate width.
REQ-004 Parameter COLOUR_W, default 1: pixel data width, 1..8.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port BUS_ADDR, input, 8: bus address.
REQ-008 Port BUS_DATA_IN, input, 8: bus write data.
REQ-009 Port BUS_WE, input, 1: bus write strobe, one cycle per write.
REQ-010 Port BUS_DATA_OUT, output, 8: read data; 0 when no register in this block is addressed.
REQ-011 Port BUS_DATA_OE, output, 1: high while BUS_ADDR is in range and BUS_WE is low.
REQ-012 Port fb_addr, output, V_BITS+H_BITS: frame buffer address, laid out as {V, H}.
REQ-013 Port fb_data, output, COLOUR_W: frame buffer pixel data.
REQ-014 Port fb_we, output, 1: frame buffer write request.
REQ-015 Port fb_ready, input, 1: frame buffer accepts the write in any cycle where fb_we and fb_ready are both high.

Function
REQ-016 Register map, as offsets from BASE_ADDR:
- +0: H
- +1: V
- +2: PIXEL; a write issues a single-pixel write
- +3: WIDTH-1
- +4: HEIGHT-1
- +5: CMD/STATUS; a write with bit0=1 starts a fill, a read returns {6'b0, overflow, busy}
REQ-017 H and V registers are truncated to H_BITS/V_BITS on write. PIXEL stores BUS_DATA_IN[COLOUR_W-1:0].
REQ-018 States: IDLE, SINGLE, FILL, DONE.
REQ-019 IDLE + PIXEL write -> SINGLE. In SINGLE, fb_we=1, fb_addr={V,H}, fb_data=PIXEL. The state holds until fb_ready, then returns to IDLE. fb_we rises the cycle after the bus write.
REQ-020 IDLE + CMD bit0 write -> FILL. Writes run row-major from (H,V) to (H+WIDTH-1, V+HEIGHT-1), one pixel per accepted handshake. The column counter resets to H on each new row.
REQ-021 Coordinate arithmetic wraps modulo 2^H_BITS and 2^V_BITS; wrapped pixels are still written.
REQ-022 The final accepted fill write -> DONE for one cycle -> IDLE.
REQ-023 busy=1 in every state except IDLE.
REQ-024 Bus writes to offsets +0..+5 while busy are ignored and set the sticky overflow bit. Overflow is cleared only by a CMD write with bit1=1 while IDLE.
REQ-025 fb_addr and fb_data hold stable while fb_we=1 and fb_ready=0.
REQ-026 A PIXEL write and a CMD write cannot coincide, since there is one address per cycle. A CMD write with bit0=0 starts nothing.
REQ-027 WIDTH-1=0 and HEIGHT-1=0 is a valid fill and produces exactly one write.

Reset
REQ-028 On reset:
- state=IDLE
- H, V, PIXEL, WIDTH-1, HEIGHT-1 and overflow = 0
- fb_we=0, fb_addr=0, fb_data=0
REQ-029 Reset during SINGLE or FILL aborts the operation the next edge; no further fb_we is issued.

Configuration
REQ-030 Macro VGA_DRAW_AUTO_INC_EN:
- Defined: each accepted SINGLE write increments H. On wrap of H to 0, V also increments, modulo 2^V_BITS.
- Undefined: H and V change only on bus writes.

Structure
REQ-031 Shared package vga_pkg holds:
- register offset constants
- the state enum
- STATUS bit positions
REQ-032 One sub-module, vga_rect_scan: the column/row counter pair with start, advance and last outputs, used by FILL.

Verification
REQ-033 Single write: write H=8'h05, V=8'h03, PIXEL=1 with fb_ready=1 -> one fb_we pulse with fb_addr=15'h0305, fb_data=1, then busy=0.
REQ-034 Fill: H=2, V=1, WIDTH-1=1, HEIGHT-1=1, CMD=1 -> four writes in order: addresses 0x0102, 0x0103, 0x0202, 0x0203.
REQ-035 Backpressure: hold fb_ready=0 for 5 cycles during a fill -> fb_addr and fb_data stable, no pixel skipped or repeated.
REQ-036 Overflow: write H while busy -> H unchanged and STATUS reads 8'h03. A subsequent CMD=8'h02 while IDLE -> STATUS reads 8'h00.
REQ-037 Wrap: H=8'hFF, WIDTH-1=1, HEIGHT-1=0 -> writes to H=8'hFF then H=8'h00, both on the same row.
REQ-038 Reset: assert reset mid-fill -> no fb_we on the next edge and all registers read 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared register offsets, draw-engine state encoding and STATUS bit positions
package vga_pkg;

    localparam logic [7:0] OFF_H      = 8'd0;
    localparam logic [7:0] OFF_V      = 8'd1;
    localparam logic [7:0] OFF_PIXEL  = 8'd2;
    localparam logic [7:0] OFF_WIDTH  = 8'd3;
    localparam logic [7:0] OFF_HEIGHT = 8'd4;
    localparam logic [7:0] OFF_CMD    = 8'd5;
    localparam logic [7:0] N_REGS     = 8'd6;

    localparam int ST_BUSY   = 0;
    localparam int ST_OVF    = 1;
    localparam int CMD_START = 0;
    localparam int CMD_CLR   = 1;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        FILL,
        DONE
    } state_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic busy);
        status_byte         = 8'h00;
        status_byte[ST_OVF]  = ovf;
        status_byte[ST_BUSY] = busy;
    endfunction

endpackage

// File: rtl/vga_rect_scan.sv
// vga_rect_scan: row-major column/row walker over a WIDTH x HEIGHT rectangle, exposing the next coordinate and a last flag
module vga_rect_scan #(
    parameter int H_BITS = 8,
    parameter int V_BITS = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              advance,
    input  logic [H_BITS-1:0] h0,
    input  logic [V_BITS-1:0] v0,
    input  logic [H_BITS-1:0] wm1,
    input  logic [V_BITS-1:0] hm1,
    output logic [H_BITS-1:0] nxt_h,
    output logic [V_BITS-1:0] nxt_v,
    output logic              last
);

    logic [H_BITS-1:0] col, h_base, ccnt;
    logic [V_BITS-1:0] row, rcnt;
    logic              row_end;

    // next coordinate wraps naturally in the counter widths; column restarts at the saved base
    always_comb begin
        row_end = ccnt == wm1;
        last    = row_end && rcnt == hm1;
        nxt_h   = row_end ? h_base : col + H_BITS'(1);
        nxt_v   = row_end ? row + V_BITS'(1) : row;
    end

    // counters load on start and step once per accepted pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            h_base <= '0;
            ccnt   <= '0;
            rcnt   <= '0;
        end else if (start) begin
            col    <= h0;
            row    <= v0;
            h_base <= h0;
            ccnt   <= '0;
            rcnt   <= '0;
        end else if (advance) begin
            col  <= nxt_h;
            row  <= nxt_v;
            ccnt <= row_end ? '0 : ccnt + H_BITS'(1);
            rcnt <= row_end ? rcnt + V_BITS'(1) : rcnt;
        end
    end

endmodule

// File: rtl/vga_draw_engine.sv
// vga_draw_engine: bus-mapped single-pixel and rectangle-fill writer; `define VGA_DRAW_AUTO_INC_EN to auto-advance H/V after single writes
module vga_draw_engine
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         H_BITS    = 8,
    parameter int         V_BITS    = 7,
    parameter int         COLOUR_W  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               BUS_ADDR,
    input  logic [7:0]               BUS_DATA_IN,
    input  logic                     BUS_WE,
    output logic [7:0]               BUS_DATA_OUT,
    output logic                     BUS_DATA_OE,
    output logic [V_BITS+H_BITS-1:0] fb_addr,
    output logic [COLOUR_W-1:0]      fb_data,
    output logic                     fb_we,
    input  logic                     fb_ready
);

    state_t              state;
    logic [H_BITS-1:0]   h_reg, wm1;
    logic [V_BITS-1:0]   v_reg, hm1;
    logic [COLOUR_W-1:0] pix;
    logic                ovf;
    logic [7:0]          off;
    logic                in_range, wr, rd, busy, scan_start, scan_adv, scan_last;
    logic [H_BITS-1:0]   nxt_h;
    logic [V_BITS-1:0]   nxt_v;

    // address decode and register readback; subtraction keeps the window correct near address wrap
    always_comb begin
        off          = BUS_ADDR - BASE_ADDR;
        in_range     = off < N_REGS;
        wr           = in_range && BUS_WE;
        rd           = in_range && !BUS_WE;
        busy         = state != IDLE;
        BUS_DATA_OE  = rd;
        BUS_DATA_OUT = !rd                ? 8'h00 :
                       off == OFF_H       ? 8'(h_reg) :
                       off == OFF_V       ? 8'(v_reg) :
                       off == OFF_PIXEL   ? 8'(pix) :
                       off == OFF_WIDTH   ? 8'(wm1) :
                       off == OFF_HEIGHT  ? 8'(hm1) :
                                            status_byte(ovf, busy);
        scan_start   = state == IDLE && wr && off == OFF_CMD && BUS_DATA_IN[CMD_START];
        scan_adv     = state == FILL && fb_ready;
    end

    vga_rect_scan #(
        .H_BITS(H_BITS),
        .V_BITS(V_BITS)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .start  (scan_start),
        .advance(scan_adv),
        .h0     (h_reg),
        .v0     (v_reg),
        .wm1    (wm1),
        .hm1    (hm1),
        .nxt_h  (nxt_h),
        .nxt_v  (nxt_v),
        .last   (scan_last)
    );

    // register file and draw FSM; fb_* are registered so they stay put while fb_ready is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            h_reg   <= '0;
            v_reg   <= '0;
            pix     <= '0;
            wm1     <= '0;
            hm1     <= '0;
            ovf     <= 1'b0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            if (wr && busy) ovf <= 1'b1;
            case (state)
                IDLE: if (wr) begin
                    case (off)
                        OFF_H:      h_reg <= BUS_DATA_IN[H_BITS-1:0];
                        OFF_V:      v_reg <= BUS_DATA_IN[V_BITS-1:0];
                        OFF_WIDTH:  wm1   <= BUS_DATA_IN[H_BITS-1:0];
                        OFF_HEIGHT: hm1   <= BUS_DATA_IN[V_BITS-1:0];
                        OFF_PIXEL: begin
                            pix     <= BUS_DATA_IN[COLOUR_W-1:0];
                            state   <= SINGLE;
                            fb_we   <= 1'b1;
                            fb_addr <= {v_reg, h_reg};
                            fb_data <= BUS_DATA_IN[COLOUR_W-1:0];
                        end
                        OFF_CMD: begin
                            if (BUS_DATA_IN[CMD_CLR]) ovf <= 1'b0;
                            if (BUS_DATA_IN[CMD_START]) begin
                                state   <= FILL;
                                fb_we   <= 1'b1;
                                fb_addr <= {v_reg, h_reg};
                                fb_data <= pix;
                            end
                        end
                        default: ;
                    endcase
                end
                SINGLE: if (fb_ready) begin
                    fb_we <= 1'b0;
                    state <= IDLE;
`ifdef VGA_DRAW_AUTO_INC_EN
                    h_reg <= h_reg + H_BITS'(1);
                    if (&h_reg) v_reg <= v_reg + V_BITS'(1);
`endif
                end
                FILL: if (fb_ready) begin
                    if (scan_last) begin
                        fb_we <= 1'b0;
                        state <= DONE;
                    end else begin
                        fb_addr <= {nxt_v, nxt_h};
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
